ecc_lockstep_chk: RTL and testbench

- Pipelined, parametrised successor of the dual-redundant SECDED decode checker.
- Two identical decoders process every valid word and their syndrome results are compared. The output stage is registered.
- Mismatches are counted, latched as sticky status, and escalated to a fatal flag at a threshold.
- An on-demand self-test injects a mismatch into the shadow decoder to prove the comparator works. Sits on the FIFO read path, between RAM read data and the consumer.

---
 rtl/ecc_chk_pkg.sv | 29 ++
 rtl/ecc_secded_cal.sv | 47 ++++
 rtl/ecc_lockstep_chk.sv | 146 ++++++++++++++
 tb/tb_ecc_lockstep_chk.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_chk_pkg.sv
// Shared types and helpers for the lockstep SECDED checker: self-test states,
// codeword layout and parameter sanity checks.
package ecc_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_CHECK = 2'd2
    } st_state_t;

    // Shadow mask bit flipped by the self-test.
    localparam int INJ_BIT = 0;

    // Hamming positions must cover data plus check bits.
    function automatic bit secded_params_ok(input int dw, input int pw);
        return (64'(1) << (pw - 1)) >= 64'(dw + pw);
    endfunction

    // Codeword position (1-based) of data bit j, skipping power-of-two check slots.
    function automatic int data_pos(input int j);
        int p;
        p = j + 1;
        for (int k = 0; k < 31; k++) begin
            if ((1 << k) <= p) p++;
        end
        return p;
    endfunction

endpackage

// File: rtl/ecc_secded_cal.sv
// Combinational SECDED decoder: Hamming syndrome over positions 1..N plus an
// overall parity bit in the top check bit.
module ecc_secded_cal
    import ecc_chk_pkg::*;
#(
    parameter int DATA_WIDTH   = 198,
    parameter int PARITY_WIDTH = 9
) (
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    input  logic                    bypass,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic [DATA_WIDTH-1:0]   mask,
    output logic                    sbit_err,
    output logic                    dbit_err
);

    localparam int HW = PARITY_WIDTH - 1;

    logic [HW-1:0] pos_tbl [DATA_WIDTH];
    logic [HW-1:0] syndrome;
    logic          overall;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
            localparam logic [HW-1:0] POS = HW'(data_pos(gi));
            assign pos_tbl[gi] = POS;
            assign mask[gi]    = sbit_err && (syndrome == POS);
        end
    endgenerate

    always_comb begin
        syndrome = parity_in[HW-1:0];
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if (data_in[j]) syndrome = syndrome ^ pos_tbl[j];
        end
    end

    // Odd overall parity means one flipped bit; even parity with a nonzero
    // syndrome means two.
    assign overall  = ^{data_in, parity_in};
    assign sbit_err = !bypass && overall;
    assign dbit_err = !bypass && !overall && (syndrome != '0);
    assign data_out = data_in ^ mask;

endmodule

// File: rtl/ecc_lockstep_chk.sv
// Dual-redundant SECDED decode checker with registered outputs, mismatch
// accounting and a comparator self-test.
module ecc_lockstep_chk
    import ecc_chk_pkg::*;
#(
    parameter int DATA_WIDTH   = 198,
    parameter int PARITY_WIDTH = 9,
    parameter int CNT_WIDTH    = 8,
    parameter int FATAL_THRESH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [PARITY_WIDTH-1:0] parity_in,
    input  logic                    bypass,
    input  logic                    chk_en,
    input  logic                    st_start,
    input  logic                    stat_clr,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    sbit_err,
    output logic                    dbit_err,
    output logic                    ecc_fault,
    output logic                    fault_sticky,
    output logic [CNT_WIDTH-1:0]    fault_cnt,
    output logic                    fault_fatal,
    output logic                    st_busy,
    output logic                    st_done,
    output logic                    st_pass
);

    localparam bit PARAMS_OK = secded_params_ok(DATA_WIDTH, PARITY_WIDTH)
                               && (FATAL_THRESH >= 1)
                               && (FATAL_THRESH <= (2 ** CNT_WIDTH) - 1);
    localparam logic [CNT_WIDTH-1:0] THRESH = CNT_WIDTH'(FATAL_THRESH);

    generate
        if (!PARAMS_OK) begin : g_param_err
            $error("ecc_lockstep_chk: illegal PARITY_WIDTH or FATAL_THRESH");
        end
    endgenerate

    st_state_t             state_reg, state_next;
    logic [DATA_WIDTH-1:0] pri_data, pri_mask, sha_data, sha_mask, sha_mask_cmp;
    logic                  pri_sbit, pri_dbit, sha_sbit, sha_dbit;
    logic                  inj, mismatch, fault;
    logic                  inj_mis_reg;
    logic                  st_done_next, st_pass_next;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  unused_sha;

    ecc_secded_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_pri (
        .data_in(data_in), .parity_in(parity_in), .bypass(bypass),
        .data_out(pri_data), .mask(pri_mask), .sbit_err(pri_sbit), .dbit_err(pri_dbit)
    );

    ecc_secded_cal #(.DATA_WIDTH(DATA_WIDTH), .PARITY_WIDTH(PARITY_WIDTH)) u_sha (
        .data_in(data_in), .parity_in(parity_in), .bypass(bypass),
        .data_out(sha_data), .mask(sha_mask), .sbit_err(sha_sbit), .dbit_err(sha_dbit)
    );

    // Shadow corrected data is implied by its mask, so only the mask is compared.
    assign unused_sha = ^sha_data;

    assign inj          = (state_reg == ST_ARMED) && in_valid;
    assign sha_mask_cmp = sha_mask ^ (DATA_WIDTH'(inj) << INJ_BIT);
    assign mismatch     = (|(pri_mask ^ sha_mask_cmp)) | (pri_sbit ^ sha_sbit) | (pri_dbit ^ sha_dbit);
    assign fault        = in_valid && mismatch && chk_en && !inj;
    assign cnt_next     = (fault_cnt == '1) ? fault_cnt : fault_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            data_out  <= '0;
            sbit_err  <= 1'b0;
            dbit_err  <= 1'b0;
            ecc_fault <= 1'b0;
        end else begin
            out_valid <= in_valid;
            ecc_fault <= fault && !stat_clr;
            if (in_valid) begin
                data_out <= (!mismatch || !chk_en) ? pri_data : data_in;
                sbit_err <= pri_sbit;
                dbit_err <= pri_dbit;
            end
        end
    end

    // A clear in the same cycle as a fault drops that fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_cnt    <= '0;
            fault_sticky <= 1'b0;
            fault_fatal  <= 1'b0;
        end else if (stat_clr) begin
            fault_cnt    <= '0;
            fault_sticky <= 1'b0;
            fault_fatal  <= 1'b0;
        end else if (fault) begin
            fault_cnt    <= cnt_next;
            fault_sticky <= 1'b1;
            if (cnt_next >= THRESH) fault_fatal <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            inj_mis_reg <= 1'b0;
            st_done     <= 1'b0;
            st_pass     <= 1'b0;
        end else begin
            state_reg <= state_next;
            st_done   <= st_done_next;
            st_pass   <= st_pass_next;
            if (inj) inj_mis_reg <= mismatch;
        end
    end

    always_comb begin
        state_next   = state_reg;
        st_done_next = 1'b0;
        st_pass_next = st_pass;
        case (state_reg)
            ST_IDLE: begin
                if (st_start) begin
                    state_next   = ST_ARMED;
                    st_pass_next = 1'b0;
                end
            end
            ST_ARMED: begin
                if (in_valid) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                state_next   = ST_IDLE;
                st_done_next = 1'b1;
                st_pass_next = inj_mis_reg;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign st_busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ecc_lockstep_chk.sv
// Scoreboard bench for ecc_lockstep_chk: directed words push expected results,
// a negedge monitor pops and compares on every out_valid.
module tb_ecc_lockstep_chk;

    localparam int DW = 198;
    localparam int PW = 9;
    localparam int CW = 8;
    localparam int TH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [PW-1:0] parity_in = '0;
    logic          bypass = 1'b0;
    logic          chk_en = 1'b1;
    logic          st_start = 1'b0;
    logic          stat_clr = 1'b0;
    logic          out_valid;
    logic [DW-1:0] data_out;
    logic          sbit_err, dbit_err, ecc_fault, fault_sticky, fault_fatal;
    logic [CW-1:0] fault_cnt;
    logic          st_busy, st_done, st_pass;

    ecc_lockstep_chk #(.DATA_WIDTH(DW), .PARITY_WIDTH(PW), .CNT_WIDTH(CW), .FATAL_THRESH(TH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .parity_in(parity_in),
        .bypass(bypass), .chk_en(chk_en), .st_start(st_start), .stat_clr(stat_clr),
        .out_valid(out_valid), .data_out(data_out), .sbit_err(sbit_err), .dbit_err(dbit_err),
        .ecc_fault(ecc_fault), .fault_sticky(fault_sticky), .fault_cnt(fault_cnt),
        .fault_fatal(fault_fatal), .st_busy(st_busy), .st_done(st_done), .st_pass(st_pass)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          sbit;
        logic          dbit;
        logic          fault;
        logic [CW-1:0] cnt;
        logic          sticky;
        logic          fatal;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;
    int   m_cnt    = 0;
    logic m_sticky = 1'b0;
    logic m_fatal  = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Independent encoder: walks codeword positions, skipping check-bit slots.
    function automatic logic [PW-1:0] encode(input logic [DW-1:0] d);
        logic [PW-1:0] p;
        int pos;
        p = '0;
        pos = 1;
        for (int j = 0; j < DW; j++) begin
            while ((pos & (pos - 1)) == 0) pos++;
            for (int i = 0; i < PW - 1; i++) begin
                if (pos[i]) p[i] = p[i] ^ d[j];
            end
            pos++;
        end
        p[PW-1] = ^{d, p[PW-2:0]};
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one word; frc makes the shadow mask disagree with the primary.
    task automatic send(input logic [DW-1:0] d, input logic [PW-1:0] p, input logic frc,
                        input logic clr, input logic inj_m, input logic [DW-1:0] exp_data,
                        input logic exp_sbit, input logic exp_dbit);
        exp_t e;
        logic f;
        f = frc && chk_en && !inj_m;
        if (clr) begin
            m_cnt = 0; m_sticky = 1'b0; m_fatal = 1'b0; f = 1'b0;
        end else if (f) begin
            if (m_cnt != 255) m_cnt++;
            m_sticky = 1'b1;
            if (m_cnt >= TH) m_fatal = 1'b1;
        end
        e.data = exp_data; e.sbit = exp_sbit; e.dbit = exp_dbit; e.fault = f;
        e.cnt = CW'(m_cnt); e.sticky = m_sticky; e.fatal = m_fatal;
        sb_q.push_back(e);
        in_valid = 1'b1; data_in = d; parity_in = p; stat_clr = clr;
        if (frc) force dut.sha_mask = '0;
        step();
        release dut.sha_mask;
        in_valid = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        check({tag, "_data_out"}, 256'(data_out), 256'(0));
        check({tag, "_flags"}, 256'({sbit_err, dbit_err, ecc_fault}), 256'(0));
        check({tag, "_status"}, 256'({fault_sticky, fault_fatal, fault_cnt}), 256'(0));
        check({tag, "_selftest"}, 256'({st_busy, st_done, st_pass}), 256'(0));
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got out_valid=1 required no pending word");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                n_txn++;
                $display("[txn %0d] data_out=%h sbit=%b dbit=%b fault=%b cnt=%0d sticky=%b fatal=%b",
                         n_txn, data_out, sbit_err, dbit_err, ecc_fault, fault_cnt, fault_sticky, fault_fatal);
                check("data_out", 256'(data_out), 256'(e.data));
                check("sbit_err", 256'(sbit_err), 256'(e.sbit));
                check("dbit_err", 256'(dbit_err), 256'(e.dbit));
                check("ecc_fault", 256'(ecc_fault), 256'(e.fault));
                check("fault_cnt", 256'(fault_cnt), 256'(e.cnt));
                check("fault_sticky", 256'(fault_sticky), 256'(e.sticky));
                check("fault_fatal", 256'(fault_fatal), 256'(e.fatal));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] one, d0, d1, e57, e2;
        logic [PW-1:0] p0, p1;
        one = 1;
        d0  = {66'h2_DEAD_BEEF_0123_4567, 66'h1_1234_5678_9ABC_DEF0, 66'h3_0F0F_F0F0_A5A5_5A5A};
        d1  = ~d0;
        p0  = encode(d0);
        p1  = encode(d1);
        e57 = d0 ^ (one << 57);
        e2  = d0 ^ (one << 3) ^ (one << 100);

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        step();

        // Decode: clean, single-bit, double-bit, second clean pattern.
        send(d0, p0, 1'b0, 1'b0, 1'b0, d0, 1'b0, 1'b0);
        send(e57, p0, 1'b0, 1'b0, 1'b0, d0, 1'b1, 1'b0);
        send(e2, p0, 1'b0, 1'b0, 1'b0, e2, 1'b0, 1'b1);
        send(d1, p1, 1'b0, 1'b0, 1'b0, d1, 1'b0, 1'b0);

        // Four forced mismatches: raw data passes through, fatal at the 4th.
        for (int i = 0; i < 4; i++) send(e57, p0, 1'b1, 1'b0, 1'b0, e57, 1'b1, 1'b0);
        step();
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        m_cnt = 0; m_sticky = 1'b0; m_fatal = 1'b0;
        check("clr_status", 256'({fault_sticky, fault_fatal, fault_cnt}), 256'(0));

        // chk_en=0: mismatch ignored, corrected data delivered.
        chk_en = 1'b0;
        send(e57, p0, 1'b1, 1'b0, 1'b0, d0, 1'b1, 1'b0);
        chk_en = 1'b1;
        // bypass: raw data, flags forced low.
        bypass = 1'b1;
        send(e57, p0, 1'b0, 1'b0, 1'b0, e57, 1'b0, 1'b0);
        bypass = 1'b0;

        // Saturation, then clear colliding with a fault.
        for (int i = 0; i < 300; i++) send(e57, p0, 1'b1, 1'b0, 1'b0, e57, 1'b1, 1'b0);
        send(e57, p0, 1'b1, 1'b1, 1'b0, e57, 1'b1, 1'b0);

        // One real fault so "count unchanged" during self-test is meaningful.
        send(e57, p0, 1'b1, 1'b0, 1'b0, e57, 1'b1, 1'b0);

        // Self-test on a clean word.
        st_start = 1'b1;
        step();
        st_start = 1'b0;
        check("st_busy_armed", 256'(st_busy), 256'(1));
        check("st_pass_cleared", 256'(st_pass), 256'(0));
        for (int i = 0; i < 3; i++) begin
            step();
            check("st_busy_wait", 256'({st_busy, st_done}), 256'(2'b10));
        end
        send(d0, p0, 1'b0, 1'b0, 1'b1, d0, 1'b0, 1'b0);
        check("st_check_state", 256'({st_busy, st_done}), 256'(2'b10));
        st_start = 1'b1;
        step();
        st_start = 1'b0;
        check("st_done_pulse", 256'({st_busy, st_done, st_pass}), 256'(3'b011));
        step();
        check("st_after_done", 256'({st_busy, st_done, st_pass}), 256'(3'b001));

        // Self-test under bypass still detects the injected mismatch.
        bypass = 1'b1;
        st_start = 1'b1;
        step();
        st_start = 1'b0;
        check("st_bypass_pass_cleared", 256'(st_pass), 256'(0));
        send(e57, p0, 1'b0, 1'b0, 1'b1, e57, 1'b0, 1'b0);
        step();
        check("st_bypass_done", 256'({st_busy, st_done, st_pass}), 256'(3'b011));
        bypass = 1'b0;
        step();

        // Asynchronous reset while armed; a repeated st_start is ignored.
        st_start = 1'b1;
        step();
        step();
        st_start = 1'b0;
        check("st_busy_restart", 256'(st_busy), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        step();
        step();
        rst = 1'b0;
        m_cnt = 0; m_sticky = 1'b0; m_fatal = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_idle", 256'({st_busy, st_done, st_pass}), 256'(0));
        end
        send(d1, p1, 1'b0, 1'b0, 1'b0, d1, 1'b0, 1'b0);
        step();
        check("scoreboard_empty", 256'(sb_q.size()), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
